// File: rtl/cache_control_nway_if.sv
`default_nettype none
// cache_control_nway_if: CPU port, physical-memory port and datapath control bundle
// for the N-way cache controller. Rev 1.0
interface cache_control_nway_if #(
  parameter int WAYS        = 4,
  parameter int INDEX_WIDTH = 3,
  parameter int CNT_WIDTH   = 16
) ();
  localparam int WAY_W = $clog2(WAYS);

  logic                   mem_read;
  logic                   mem_write;
  logic                   mem_resp;
  logic                   pmem_read;
  logic                   pmem_write;
  logic                   pmem_resp;
  logic [INDEX_WIDTH-1:0] index;
  logic [WAYS-1:0]        valid;
  logic [WAYS-1:0]        hit;
  logic [WAYS-1:0]        dirty;
  logic [WAY_W-1:0]       way_sel;
  logic [WAYS-1:0]        write_en;
  logic                   valid_data;
  logic                   dirty_data;
  logic                   datain_sel;
  logic                   pmem_addr_sel;
  logic [CNT_WIDTH-1:0]   hit_count;
  logic [CNT_WIDTH-1:0]   miss_count;

  modport master (
    output mem_read, mem_write, pmem_resp, index, valid, hit, dirty,
    input  mem_resp, pmem_read, pmem_write, way_sel, write_en, valid_data,
           dirty_data, datain_sel, pmem_addr_sel, hit_count, miss_count
  );

  modport slave (
    input  mem_read, mem_write, pmem_resp, index, valid, hit, dirty,
    output mem_resp, pmem_read, pmem_write, way_sel, write_en, valid_data,
           dirty_data, datain_sel, pmem_addr_sel, hit_count, miss_count
  );
endinterface
`default_nettype wire

// File: rtl/cache_control_nway.sv
`default_nettype none
// cache_control_nway: N-way write-back cache controller with tree pLRU replacement,
// latched miss victim and saturating hit/miss counters. Rev 1.0
module cache_control_nway #(
  parameter int WAYS        = 4,
  parameter int INDEX_WIDTH = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  cache_control_nway_if.slave bus
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SETS  = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    FILL       = 2'd2,
    FILL_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WAY_W-1:0]     victim_q, victim_d;
  logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;
  logic [WAYS-1:1]      lru_q [SETS];
  logic [WAYS-1:1]      lru_d [SETS];

  logic             legal;
  logic             any_hit;
  logic [WAY_W-1:0] hit_way;
  logic             any_invalid;
  logic [WAY_W-1:0] invalid_way;
  logic [WAY_W-1:0] plru_way;
  logic [WAY_W-1:0] miss_victim;
  logic [WAYS-1:1]  lru_cur;
  logic [WAYS-1:1]  lru_new;
  logic             lru_we;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W:0]   walk_node;
  logic [WAY_W:0]   upd_node;

  logic             mem_resp_o, pmem_read_o, pmem_write_o;
  logic [WAY_W-1:0] way_sel_o;
  logic [WAYS-1:0]  write_en_o;
  logic             valid_data_o, dirty_data_o, datain_sel_o, pmem_addr_sel_o;

  assign legal   = bus.mem_read ^ bus.mem_write;
  assign lru_cur = lru_q[bus.index];

  always_comb begin
    any_hit     = 1'b0;
    hit_way     = '0;
    any_invalid = 1'b0;
    invalid_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (bus.hit[w]) begin
        any_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!bus.valid[w]) begin
        any_invalid = 1'b1;
        invalid_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    walk_node = (WAY_W + 1)'(1);
    for (int l = 0; l < WAY_W; l++) begin
      walk_node = {walk_node[WAY_W-1:0], lru_cur[walk_node[WAY_W-1:0]]};
    end
    plru_way    = walk_node[WAY_W-1:0];
    miss_victim = any_invalid ? invalid_way : plru_way;
  end

  // Every node on the accessed leaf's path is turned to point at the other subtree.
  always_comb begin
    lru_new  = lru_cur;
    upd_node = {1'b1, lru_way};
    for (int l = 0; l < WAY_W; l++) begin
      lru_new[upd_node[WAY_W:1]] = ~upd_node[0];
      upd_node = upd_node >> 1;
    end
    lru_d = lru_q;
    if (lru_we) begin
      lru_d[bus.index] = lru_new;
    end
  end

  always_comb begin
    state_d         = state_q;
    victim_d        = victim_q;
    hit_count_d     = hit_count_q;
    miss_count_d    = miss_count_q;
    lru_we          = 1'b0;
    lru_way         = hit_way;
    mem_resp_o      = 1'b0;
    pmem_read_o     = 1'b0;
    pmem_write_o    = 1'b0;
    way_sel_o       = hit_way;
    write_en_o      = '0;
    valid_data_o    = 1'b0;
    dirty_data_o    = 1'b0;
    datain_sel_o    = 1'b0;
    pmem_addr_sel_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (legal) begin
          if (any_hit) begin
            mem_resp_o  = 1'b1;
            lru_we      = 1'b1;
            hit_count_d = (hit_count_q == '1) ? hit_count_q : hit_count_q + 1'b1;
            if (bus.mem_write) begin
              write_en_o   = WAYS'(1) << hit_way;
              valid_data_o = 1'b1;
              dirty_data_o = 1'b1;
            end
          end else begin
            victim_d     = miss_victim;
            miss_count_d = (miss_count_q == '1) ? miss_count_q : miss_count_q + 1'b1;
            state_d      = bus.dirty[miss_victim] ? WRITE_BACK : FILL;
          end
        end
      end
      WRITE_BACK: begin
        pmem_write_o    = 1'b1;
        pmem_addr_sel_o = 1'b1;
        way_sel_o       = victim_q;
        if (bus.pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read_o = 1'b1;
        if (bus.pmem_resp) state_d = FILL_DONE;
      end
      FILL_DONE: begin
        write_en_o   = WAYS'(1) << victim_q;
        valid_data_o = 1'b1;
        datain_sel_o = 1'b1;
        way_sel_o    = victim_q;
        lru_we       = 1'b1;
        lru_way      = victim_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Combinational outputs must also drop while reset is held.
    if (!rst_n) begin
      mem_resp_o      = 1'b0;
      pmem_read_o     = 1'b0;
      pmem_write_o    = 1'b0;
      way_sel_o       = '0;
      write_en_o      = '0;
      valid_data_o    = 1'b0;
      dirty_data_o    = 1'b0;
      datain_sel_o    = 1'b0;
      pmem_addr_sel_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      victim_q     <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        lru_q[s] <= '0;
      end
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      lru_q        <= lru_d;
    end
  end

  assign bus.mem_resp      = mem_resp_o;
  assign bus.pmem_read     = pmem_read_o;
  assign bus.pmem_write    = pmem_write_o;
  assign bus.way_sel       = way_sel_o;
  assign bus.write_en      = write_en_o;
  assign bus.valid_data    = valid_data_o;
  assign bus.dirty_data    = dirty_data_o;
  assign bus.datain_sel    = datain_sel_o;
  assign bus.pmem_addr_sel = pmem_addr_sel_o;
  assign bus.hit_count     = hit_count_q;
  assign bus.miss_count    = miss_count_q;
endmodule
`default_nettype wire

// File: tb/tb_cache_control_nway.sv
`default_nettype none
// tb_cache_control_nway: directed bench for cache_control_nway (4 ways, 4-bit counters
// so saturation is reachable). Rev 1.0
module tb_cache_control_nway;
  localparam int WAYS = 4;
  localparam int IW   = 3;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_control_nway_if #(.WAYS(WAYS), .INDEX_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

  cache_control_nway #(.WAYS(WAYS), .INDEX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int exp_hit  = 0;
  int exp_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x >= CMAX) ? CMAX : x + 1;
  endfunction

  task automatic clear_inputs();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.pmem_resp = 1'b0;
    bus.index     = '0;
    bus.valid     = '0;
    bus.hit       = '0;
    bus.dirty     = '0;
  endtask

  // Full read-miss sequence ending in the response hit; valid/dirty are scrambled
  // mid-FILL to show the latched victim is not recomputed.
  task automatic miss(input logic [IW-1:0] idx, input logic [3:0] v, input logic [3:0] d,
                      input int way, input bit wb);
    logic [3:0] onehot;
    onehot = 4'b0001 << way;
    @(negedge clk);
    bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.index = idx;
    bus.valid = v; bus.dirty = d; bus.hit = '0; bus.pmem_resp = 1'b0;
    #1;
    check("miss_idle_resp", bus.mem_resp, 0);
    check("miss_idle_pread", bus.pmem_read, 0);
    exp_miss = sat(exp_miss);
    if (wb) begin
      @(negedge clk); #1;
      check("wb_pwrite", bus.pmem_write, 1);
      check("wb_pread", bus.pmem_read, 0);
      check("wb_addr_sel", bus.pmem_addr_sel, 1);
      check("wb_way_sel", bus.way_sel, way);
      check("wb_miss_cnt", bus.miss_count, exp_miss);
      bus.pmem_resp = 1'b1;
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    check("fill_pread", bus.pmem_read, 1);
    check("fill_pwrite", bus.pmem_write, 0);
    check("fill_addr_sel", bus.pmem_addr_sel, 0);
    check("fill_miss_cnt", bus.miss_count, exp_miss);
    @(negedge clk);
    bus.valid = 4'hf; bus.dirty = 4'hf; bus.pmem_resp = 1'b1;
    #1;
    check("fill_hold_pread", bus.pmem_read, 1);
    @(negedge clk);
    bus.pmem_resp = 1'b0; bus.valid = v; bus.dirty = d;
    #1;
    check("fdone_write_en", bus.write_en, onehot);
    check("fdone_valid_data", bus.valid_data, 1);
    check("fdone_dirty_data", bus.dirty_data, 0);
    check("fdone_datain_sel", bus.datain_sel, 1);
    check("fdone_way_sel", bus.way_sel, way);
    check("fdone_resp", bus.mem_resp, 0);
    check("fdone_pread", bus.pmem_read, 0);
    @(negedge clk);
    bus.valid = v | onehot; bus.dirty = d & ~onehot; bus.hit = onehot;
    #1;
    check("post_fill_resp", bus.mem_resp, 1);
    check("post_fill_way_sel", bus.way_sel, way);
    check("post_fill_write_en", bus.write_en, 0);
    exp_hit = sat(exp_hit);
    @(negedge clk);
    bus.mem_read = 1'b0; bus.hit = '0;
    #1;
    check("post_fill_hit_cnt", bus.hit_count, exp_hit);
    check("post_fill_miss_cnt", bus.miss_count, exp_miss);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    bus.mem_read = 1'b1; bus.hit = 4'b0001; bus.valid = 4'b0001;
    #12;
    check("rst_resp", bus.mem_resp, 0);
    check("rst_way_sel", bus.way_sel, 0);
    check("rst_write_en", bus.write_en, 0);
    check("rst_pread", bus.pmem_read, 0);
    check("rst_hit_cnt", bus.hit_count, 0);
    check("rst_miss_cnt", bus.miss_count, 0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;

    // Clean miss to index 2, all invalid -> way 0.
    miss(3'd2, 4'b0000, 4'b0000, 0, 1'b0);

    // Fill all four ways of index 5 in order.
    miss(3'd5, 4'b0000, 4'b0000, 0, 1'b0);
    miss(3'd5, 4'b0001, 4'b0000, 1, 1'b0);
    miss(3'd5, 4'b0011, 4'b0000, 2, 1'b0);
    miss(3'd5, 4'b0111, 4'b0000, 3, 1'b0);

    // Read hit way 0: pLRU then points at way 2.
    @(negedge clk);
    bus.mem_read = 1'b1; bus.index = 3'd5; bus.valid = 4'hf; bus.hit = 4'b0001; bus.dirty = '0;
    #1;
    check("rdhit_resp", bus.mem_resp, 1);
    check("rdhit_way_sel", bus.way_sel, 0);
    check("rdhit_write_en", bus.write_en, 0);
    exp_hit = sat(exp_hit);
    @(negedge clk);
    bus.mem_read = 1'b0; bus.hit = '0;
    #1;
    check("rdhit_hit_cnt", bus.hit_count, exp_hit);

    miss(3'd5, 4'hf, 4'b0000, 2, 1'b0);

    // Write hit way 3.
    @(negedge clk);
    bus.mem_write = 1'b1; bus.index = 3'd5; bus.valid = 4'hf; bus.hit = 4'b1000;
    #1;
    check("wrhit_resp", bus.mem_resp, 1);
    check("wrhit_write_en", bus.write_en, 4'b1000);
    check("wrhit_dirty_data", bus.dirty_data, 1);
    check("wrhit_valid_data", bus.valid_data, 1);
    check("wrhit_datain_sel", bus.datain_sel, 0);
    check("wrhit_way_sel", bus.way_sel, 3);
    exp_hit = sat(exp_hit);
    @(negedge clk);
    bus.mem_write = 1'b0; bus.hit = '0;
    #1;
    check("wrhit_hit_cnt", bus.hit_count, exp_hit);

    // pLRU now selects way 1, which is dirty -> write-back first.
    miss(3'd5, 4'hf, 4'b1010, 1, 1'b1);

    // Illegal read+write with a hit does nothing.
    @(negedge clk);
    bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.index = 3'd5; bus.valid = 4'hf; bus.hit = 4'b0001;
    #1;
    check("both_resp", bus.mem_resp, 0);
    check("both_write_en", bus.write_en, 0);
    @(negedge clk);
    clear_inputs();
    #1;
    check("both_hit_cnt", bus.hit_count, exp_hit);
    check("both_miss_cnt", bus.miss_count, exp_miss);
    check("both_pread", bus.pmem_read, 0);
    check("both_pwrite", bus.pmem_write, 0);

    // Stray pmem_resp in IDLE.
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    check("stray_pread", bus.pmem_read, 0);
    check("stray_pwrite", bus.pmem_write, 0);

    // Hit counter saturation.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.mem_read = 1'b1; bus.index = 3'd5; bus.valid = 4'hf; bus.hit = 4'b0001;
      #1;
      check("sat_resp", bus.mem_resp, 1);
      exp_hit = sat(exp_hit);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    check("sat_hit_cnt", bus.hit_count, CMAX);

    // Reset in the middle of FILL.
    bus.mem_read = 1'b1; bus.index = 3'd5; bus.valid = 4'hf; bus.dirty = '0;
    @(negedge clk);
    #1;
    check("prereset_pread", bus.pmem_read, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_pread", bus.pmem_read, 0);
    check("midrst_write_en", bus.write_en, 0);
    check("midrst_hit_cnt", bus.hit_count, 0);
    check("midrst_miss_cnt", bus.miss_count, 0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    exp_hit  = 0;
    exp_miss = 0;

    // All ways valid, pLRU cleared -> way 0.
    miss(3'd5, 4'hf, 4'b0000, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
